nco_phase_sequencer: RTL and testbench
======================================

// Module: nco_phase_sequencer
// PURPOSE
// - Drives the per-voice/per-oscillator NCO state RAM: on every sample tick it sweeps all
//   VOICES*V_OSC slots, reads the 51-bit state, advances the phase, writes it back.
// - Sits between the pitch path (supplies phase_inc) and the wavetable lookup (consumes phase_out).
// - Owns the RAM's write port and read port A. Port B is left to other readers.
// PARAMETERS
// VOICES   32                       number of voices
// V_OSC    8                        oscillators per voice
// V_WIDTH  utils::clogb2(VOICES)    voice index width
// O_WIDTH  utils::clogb2(V_OSC)     oscillator index width (SW = V_WIDTH+O_WIDTH below)
// PORTS
// sCLK_XVXENVS   in   1    single system clock
// reset_reg_N    in   1    synchronous, active-low reset
// sample_tick    in   1    one-cycle pulse that starts a sweep
// phase_inc      in   32   increment for slot inc_slot; sampled in the same cycle
// inc_slot       out  SW   slot whose increment is required this cycle
// reada_address  out  SW   RAM read-port-A address
// qa             in   51   RAM read-port-A data
// write_address  out  SW   RAM write address; leads d/we by one cycle
// d              out  51   RAM write data
// we             out  1    RAM write enable
// phase_out      out  32   updated phase, to wavetable lookup
// phase_slot     out  SW   slot of phase_out
// phase_valid    out  1    phase_out/phase_slot valid
// busy           out  1    clear or sweep in progress
// sweep_done     out  1    one-cycle pulse when the last write-back has been issued
// overrun        out  1    sticky: sample_tick arrived while busy
// osc_sync_req   in   1    hard-sync request (macro only)
// osc_sync_slot  in   SW   slot to hard-sync (macro only)
// BEHAVIOUR
// - State word: [50:19] phase accumulator (32b); [18:0] reserved, written back exactly as read.
// - RAM timing is fixed:
//   - Read: address registered inside the RAM, data registered; qa is valid 2 cycles after reada_address.
//   - Write: RAM registers write_address, so address is driven in cycle t and d/we in cycle t+1.
// - States:
//   - CLEAR: entered on reset release. Writes 51'b0 to slots 0..N-1 (N=VOICES*V_OSC), one per cycle.
//   - IDLE: waits for sample_tick.
//   - SWEEP: issues read addresses.
//   - DRAIN: lets the pipeline empty; goes to IDLE with a sweep_done pulse.
// - Sweep timing (cycle 0 = cycle in which sample_tick is sampled high in IDLE):
//   - Slot k read address: cycle k+1.
//   - Slot k qa, inc_slot=k, write_address=k: cycle k+3.
//   - Slot k d/we, phase_out, phase_slot=k, phase_valid: cycle k+4.
//   - sweep_done=1 and busy=0: cycle N+4.
// - Arithmetic: new_phase = qa[50:19] + phase_inc, modulo 2^32 (wraps silently, no saturation).
// - Slot order is 0..N-1, voice-major: slot = {voice, osc}.
// - sample_tick while busy (CLEAR/SWEEP/DRAIN): tick is ignored and overrun is set.
//   - overrun clears only on reset.
// - Reset:
//   - Mid-operation reset aborts the sweep; we/phase_valid are 0 from the next cycle; state returns to CLEAR.
//   - All outputs reset to 0: addresses, d, we, phase_*, inc_slot, sweep_done, overrun. busy resets to 1 (entering CLEAR).
// - No read-after-write hazard inside a sweep: each slot is touched once. Every write of sweep n
//   completes before the first read of sweep n+1.
// CONFIGURATION
// NCO_SEQ_SYNC_EN defined:
//   - A per-slot pending-sync flop array is kept.
//   - osc_sync_req sets pending[osc_sync_slot], in any state except CLEAR.
//   - At slot k's update, if pending[k] is set: new_phase = 0 (phase_inc ignored) and pending[k] clears.
//   - A request for slot k landing in the same cycle as slot k's update is applied in the next sweep.
//   - Reset clears all pending flags.
// NCO_SEQ_SYNC_EN undefined: osc_sync_req/osc_sync_slot are ignored; no pending storage is built.
// TESTING
// - Release reset, VOICES=2,V_OSC=2 -> N=4 writes of 51'b0 to slots 0..3 (d/we one cycle after
//   write_address), then busy=0.
// - Ramp: tick with phase_inc=32'h0000_1000, qa phase 32'h10 -> phase_out=32'h1010, slot order 0..3,
//   phase_valid in cycles 4..7, sweep_done in cycle 8, qa[18:0]=19'h5A5A5 returned unchanged in d.
// - Wrap: qa phase 32'hFFFF_FF00, phase_inc 32'h200 -> phase_out=32'h100, no flag raised.
// - Tick in cycle 3 of a sweep -> ignored, overrun=1 and stays 1; the next tick in IDLE runs
//   normally, overrun still 1.
// - reset_reg_N low in cycle 5 of a sweep -> we=0 next cycle, all outputs 0, CLEAR sweep repeats.
// - NCO_SEQ_SYNC_EN: sync slot 2 before a tick -> slot 2 phase_out=0, other slots advance; the next
//   sweep advances slot 2 from 0.

Source files
------------

// File: rtl/nco_phase_sequencer.sv
// NCO state-RAM sequencer: clears the RAM after reset, then on each sample tick sweeps every
// voice/oscillator slot, advancing the 32-bit phase. Optional hard-sync: define NCO_SEQ_SYNC_EN.
module nco_phase_sequencer #(
    parameter int unsigned VOICES  = 32,
    parameter int unsigned V_OSC   = 8,
    parameter int unsigned V_WIDTH = $clog2(VOICES),
    parameter int unsigned O_WIDTH = $clog2(V_OSC)
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_reg_N,
    input  logic                       sample_tick,
    input  logic [31:0]                phase_inc,
    output logic [V_WIDTH+O_WIDTH-1:0] inc_slot,
    output logic [V_WIDTH+O_WIDTH-1:0] reada_address,
    input  logic [50:0]                qa,
    output logic [V_WIDTH+O_WIDTH-1:0] write_address,
    output logic [50:0]                d,
    output logic                       we,
    output logic [31:0]                phase_out,
    output logic [V_WIDTH+O_WIDTH-1:0] phase_slot,
    output logic                       phase_valid,
    output logic                       busy,
    output logic                       sweep_done,
    output logic                       overrun,
    input  logic                       osc_sync_req,
    input  logic [V_WIDTH+O_WIDTH-1:0] osc_sync_slot
);

    localparam int unsigned SW = V_WIDTH + O_WIDTH;
    localparam int unsigned N  = VOICES * V_OSC;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);
    localparam logic [SW:0]   CLR_END   = (SW + 1)'(N);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SWEEP, S_DRAIN} state_t;

    state_t        r_state;
    logic [SW:0]   r_clr_cnt;
    logic          r_rd_v;
    logic [SW-1:0] r_rd_addr;
    logic          r_p1_v;
    logic [SW-1:0] r_p1_slot;
    logic          r_p2_v;
    logic          r_p2_clr;
    logic [SW-1:0] r_inc_slot;
    logic [SW-1:0] r_wr_addr;
    logic [50:0]   r_d;
    logic          r_we;
    logic [31:0]   r_phase_out;
    logic [SW-1:0] r_phase_slot;
    logic          r_phase_valid;
    logic          r_busy;
    logic          r_sweep_done;
    logic          r_overrun;

    logic          w_sync_hit;
    logic [31:0]   w_new_phase;

`ifdef NCO_SEQ_SYNC_EN
    logic [N-1:0] r_pending;

    // Set after clear so a request colliding with its slot's update survives to the next sweep.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (!reset_reg_N) begin
            r_pending <= '0;
        end else begin
            if (r_p2_v && !r_p2_clr)
                r_pending[r_wr_addr] <= 1'b0;
            if (osc_sync_req && r_state != S_CLEAR)
                r_pending[osc_sync_slot] <= 1'b1;
        end
    end

    assign w_sync_hit = r_p2_v && !r_p2_clr && r_pending[r_wr_addr];
`else
    logic w_unused_sync;
    assign w_unused_sync = osc_sync_req ^ (^osc_sync_slot);
    assign w_sync_hit    = 1'b0;
`endif

    assign w_new_phase = w_sync_hit ? '0 : qa[50:19] + phase_inc;

    // Pipeline: read addr (k+1) -> RAM latency (k+2) -> qa/write addr (k+3) -> d/we (k+4).
    always_ff @(posedge sCLK_XVXENVS) begin
        if (!reset_reg_N) begin
            r_state       <= S_CLEAR;
            r_clr_cnt     <= '0;
            r_rd_v        <= 1'b0;
            r_rd_addr     <= '0;
            r_p1_v        <= 1'b0;
            r_p1_slot     <= '0;
            r_p2_v        <= 1'b0;
            r_p2_clr      <= 1'b0;
            r_inc_slot    <= '0;
            r_wr_addr     <= '0;
            r_d           <= '0;
            r_we          <= 1'b0;
            r_phase_out   <= '0;
            r_phase_slot  <= '0;
            r_phase_valid <= 1'b0;
            r_busy        <= 1'b1;
            r_sweep_done  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sweep_done  <= 1'b0;
            r_p1_v        <= r_rd_v;
            r_p1_slot     <= r_rd_addr;
            r_p2_v        <= r_p1_v;
            r_p2_clr      <= 1'b0;
            if (r_p1_v) begin
                r_inc_slot <= r_p1_slot;
                r_wr_addr  <= r_p1_slot;
            end
            r_we          <= r_p2_v;
            r_phase_valid <= r_p2_v && !r_p2_clr;
            if (r_p2_v) begin
                if (r_p2_clr) begin
                    r_d <= '0;
                end else begin
                    r_d          <= {w_new_phase, qa[18:0]};
                    r_phase_out  <= w_new_phase;
                    r_phase_slot <= r_wr_addr;
                end
            end
            if (sample_tick && r_state != S_IDLE)
                r_overrun <= 1'b1;

            case (r_state)
                S_CLEAR: begin
                    // Clear writes enter at the write-address stage; leave once the last has drained.
                    if (r_clr_cnt != CLR_END) begin
                        r_wr_addr <= r_clr_cnt[SW-1:0];
                        r_p2_v    <= 1'b1;
                        r_p2_clr  <= 1'b1;
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end else if (!r_p2_v) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (sample_tick) begin
                        r_rd_addr <= '0;
                        r_rd_v    <= 1'b1;
                        r_state   <= S_SWEEP;
                        r_busy    <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (r_rd_addr == LAST_SLOT) begin
                        r_rd_v  <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_phase_valid && r_phase_slot == LAST_SLOT) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_sweep_done <= 1'b1;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign inc_slot      = r_inc_slot;
    assign reada_address = r_rd_addr;
    assign write_address = r_wr_addr;
    assign d             = r_d;
    assign we            = r_we;
    assign phase_out     = r_phase_out;
    assign phase_slot    = r_phase_slot;
    assign phase_valid   = r_phase_valid;
    assign busy          = r_busy;
    assign sweep_done    = r_sweep_done;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_nco_phase_sequencer.sv
// Directed bench for nco_phase_sequencer with VOICES=2, V_OSC=2 and a behavioural state RAM.
module tb_nco_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset_reg_N;
    logic        sample_tick;
    logic [31:0] phase_inc;
    logic [1:0]  inc_slot;
    logic [1:0]  reada_address;
    logic [50:0] qa;
    logic [1:0]  write_address;
    logic [50:0] d;
    logic        we;
    logic [31:0] phase_out;
    logic [1:0]  phase_slot;
    logic        phase_valid;
    logic        busy;
    logic        sweep_done;
    logic        overrun;
    logic        osc_sync_req;
    logic [1:0]  osc_sync_slot;

    int total = 0;
    int bad   = 0;

    logic [50:0] mem [4];
    logic [1:0]  ra_q, wa_q;
    logic        ld_en = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [50:0] ld_data = '0;

    logic [31:0] inc_tab [4];
    logic [31:0] exp_ph  [4];
    logic [18:0] exp_res [4];
    logic        exp_ovr;

    always #5 clk = ~clk;

    nco_phase_sequencer #(.VOICES(2), .V_OSC(2)) dut (
        .sCLK_XVXENVS (clk),
        .reset_reg_N  (reset_reg_N),
        .sample_tick  (sample_tick),
        .phase_inc    (phase_inc),
        .inc_slot     (inc_slot),
        .reada_address(reada_address),
        .qa           (qa),
        .write_address(write_address),
        .d            (d),
        .we           (we),
        .phase_out    (phase_out),
        .phase_slot   (phase_slot),
        .phase_valid  (phase_valid),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .overrun      (overrun),
        .osc_sync_req (osc_sync_req),
        .osc_sync_slot(osc_sync_slot)
    );

    assign phase_inc = inc_tab[inc_slot];

    // Registered-address, registered-data read; write address registered one cycle ahead of d/we.
    always @(posedge clk) begin
        ra_q <= reada_address;
        qa   <= mem[ra_q];
        wa_q <= write_address;
        if (we)
            mem[wa_q] <= d;
        else if (ld_en)
            mem[ld_addr] <= ld_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [50:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Call in the cycle in which reset_reg_N has just been driven high.
    task automatic check_clear();
        for (int j = 0; j <= 5; j++) begin
            @(posedge clk); #1;
            if (j <= 3) chk("clr_waddr", 64'(write_address), 64'(j));
            if (j == 0) chk("clr_we0", 64'(we), 64'd0);
            if (j >= 1 && j <= 4) begin
                chk("clr_we", 64'(we), 64'd1);
                chk("clr_d", 64'(d), 64'd0);
            end
            chk("clr_busy", 64'(busy), (j == 5) ? 64'd0 : 64'd1);
            if (j == 5) chk("clr_we_end", 64'(we), 64'd0);
        end
        for (int k = 0; k < 4; k++) chk("clr_mem", 64'(mem[k]), 64'd0);
    endtask

    // Starts in an IDLE cycle; tick_at (nonzero) pulses a stray tick in that sweep cycle.
    task automatic run_sweep(input int tick_at);
        logic [50:0] wexp;
        sample_tick = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); #1;
            sample_tick = (j == tick_at);
            if (j <= 4) chk("rd_addr", 64'(reada_address), 64'(j - 1));
            if (j >= 3 && j <= 6) begin
                chk("inc_slot", 64'(inc_slot), 64'(j - 3));
                chk("wr_addr", 64'(write_address), 64'(j - 3));
            end
            if (j >= 4 && j <= 7) begin
                wexp = {exp_ph[j-4], exp_res[j-4]};
                chk("we", 64'(we), 64'd1);
                chk("pvalid", 64'(phase_valid), 64'd1);
                chk("pslot", 64'(phase_slot), 64'(j - 4));
                chk("phase", 64'(phase_out), 64'(exp_ph[j-4]));
                chk("wdata", 64'(d), 64'(wexp));
            end else begin
                chk("we_off", 64'(we), 64'd0);
                chk("pvalid_off", 64'(phase_valid), 64'd0);
            end
            chk("done", 64'(sweep_done), (j == 8) ? 64'd1 : 64'd0);
            chk("busy", 64'(busy), (j >= 8) ? 64'd0 : 64'd1);
            chk("overrun", 64'(overrun), 64'(exp_ovr || (tick_at != 0 && j > tick_at)));
        end
        if (tick_at != 0) exp_ovr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wexp = {exp_ph[k], exp_res[k]};
            chk("mem_wb", 64'(mem[k]), 64'(wexp));
        end
    endtask

    task automatic set_all(input logic [31:0] inc, input logic [31:0] ph0, input logic [31:0] ph1,
                           input logic [31:0] ph2, input logic [31:0] ph3);
        for (int k = 0; k < 4; k++) inc_tab[k] = inc;
        exp_ph[0] = ph0; exp_ph[1] = ph1; exp_ph[2] = ph2; exp_ph[3] = ph3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reg_N = 1'b0; sample_tick = 1'b0;
        osc_sync_req = 1'b0; osc_sync_slot = '0;
        exp_ovr = 1'b0;
        set_all(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        exp_res[0] = 19'h5A5A5; exp_res[1] = 19'h12345; exp_res[2] = 19'h7FFFF; exp_res[3] = 19'h00001;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) preload(2'(k), 51'h7_DEAD_BEEF_0000 + 51'(k));
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_waddr", 64'(write_address), 64'd0);
        chk("rst_raddr", 64'(reada_address), 64'd0);
        chk("rst_phase", 64'(phase_out), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_done", 64'(sweep_done), 64'd0);

        reset_reg_N = 1'b1;
        check_clear();

        // Ramp: 0x10 + 0x1000, reserved bits returned untouched.
        for (int k = 0; k < 4; k++) preload(2'(k), {32'h10, exp_res[k]});
        set_all(32'h1000, 32'h1010, 32'h1010, 32'h1010, 32'h1010);
        run_sweep(0);

        // Wrap: slot 1 at 0xFFFFFF00 + 0x200 -> 0x100.
        preload(2'd1, {32'hFFFF_FF00, exp_res[1]});
        set_all(32'h200, 32'h1210, 32'h100, 32'h1210, 32'h1210);
        run_sweep(0);

        // Stray tick in sweep cycle 3, then a normal sweep with overrun still set.
        set_all(32'h1, 32'h1211, 32'h101, 32'h1211, 32'h1211);
        run_sweep(3);
        set_all(32'h1, 32'h1212, 32'h102, 32'h1212, 32'h1212);
        run_sweep(0);

        // Reset in sweep cycle 5.
        sample_tick = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            sample_tick = 1'b0;
        end
        chk("mid_we_pre", 64'(we), 64'd1);
        reset_reg_N = 1'b0;
        @(posedge clk); #1;
        chk("mid_we", 64'(we), 64'd0);
        chk("mid_pvalid", 64'(phase_valid), 64'd0);
        chk("mid_d", 64'(d), 64'd0);
        chk("mid_phase", 64'(phase_out), 64'd0);
        chk("mid_pslot", 64'(phase_slot), 64'd0);
        chk("mid_waddr", 64'(write_address), 64'd0);
        chk("mid_raddr", 64'(reada_address), 64'd0);
        chk("mid_incslot", 64'(inc_slot), 64'd0);
        chk("mid_ovr", 64'(overrun), 64'd0);
        chk("mid_done", 64'(sweep_done), 64'd0);
        chk("mid_busy", 64'(busy), 64'd1);
        reset_reg_N = 1'b1;
        exp_ovr = 1'b0;
        check_clear();

        // Hard-sync request on slot 2 before a tick.
        for (int k = 0; k < 4; k++) exp_res[k] = '0;
        osc_sync_req = 1'b1; osc_sync_slot = 2'd2;
        @(posedge clk); #1;
        osc_sync_req = 1'b0; osc_sync_slot = '0;
`ifdef NCO_SEQ_SYNC_EN
        set_all(32'h10, 32'h10, 32'h10, 32'h0, 32'h10);
        run_sweep(0);
        set_all(32'h10, 32'h20, 32'h20, 32'h10, 32'h20);
        run_sweep(0);
`else
        set_all(32'h10, 32'h10, 32'h10, 32'h10, 32'h10);
        run_sweep(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
